// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   - op encodings (ADD/SUB/ADC/SBB)
//   - calc_c0: carry-in of the least significant segment for a given op
//   - flags_t: result flag bundle {cf, zf, of, sf}
package pipelined_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    typedef struct packed {
        logic cf;
        logic zf;
        logic of;
        logic sf;
    } flags_t;

    // Subtraction is a + ~b + c0, so SUB forces the +1 and SBB uses the
    // inverted borrow-in.
    function automatic logic calc_c0(input logic [1:0] op, input logic cin);
        logic c0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = cin;
            OP_SBB:  c0 = ~cin;
            default: c0 = 1'b0;
        endcase
        return c0;
    endfunction

endpackage

// File: rtl/pipelined_addsub_seg_cla_adder.sv
// SEG-bit carry-lookahead adder used once per pipeline stage.
// Ports:
//   a, b   : SEG-bit operands
//   cin    : carry into bit 0
//   f      : SEG-bit sum
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (for signed overflow)
module seg_cla_adder #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] f,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG-1:0] g_s;
    logic [SEG-1:0] p_s;
    logic [SEG:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Each carry is an independent sum of generate terms gated by the
    // propagates above them, so no carry depends on another carry.
    always_comb begin
        logic prop_s;
        logic term_s;
        c_s    = {(SEG + 1){1'b0}};
        c_s[0] = cin;
        prop_s = 1'b1;
        term_s = 1'b0;
        for (int i = 0; i < SEG; i++) begin
            prop_s = 1'b1;
            term_s = 1'b0;
            for (int j = i; j >= 0; j--) begin
                term_s = term_s | (g_s[j] & prop_s);
                prop_s = prop_s & p_s[j];
            end
            c_s[i+1] = term_s | (cin & prop_s);
        end
    end

    assign f     = p_s ^ c_s[SEG-1:0];
    assign cout  = c_s[SEG];
    assign c_msb = c_s[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with ADD/SUB/ADC/SBB modes.
// One SEG-bit segment is resolved per stage; the carry is registered
// between stages. Latency WIDTH/SEG cycles, one op per cycle, global stall.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake (in_ready is combinational
//                           from out_ready)
//   in_op, in_a, in_b     : op code and operands
//   in_cin                : carry/borrow-in for ADC/SBB
//   in_tag                : opaque tag returned with the result
//   out_valid/out_ready   : output handshake
//   out_f, out_cf, out_zf, out_of, out_sf, out_tag : result, flags, tag
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cf,
    output logic             out_zf,
    output logic             out_of,
    output logic             out_sf,
    output logic [TAG_W-1:0] out_tag
);
    import pipelined_addsub_pkg::*;

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SEG != 0) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be a multiple of SEG");
    end

    // Bank k holds the operation entering stage k; segments below k of
    // f are already resolved, segments at and above k of a/b are pending.
    logic [STAGES-1:0] vld_q,  vld_d;
    logic [STAGES-1:0] c_q,    c_d;
    logic [STAGES-1:0] zacc_q, zacc_d;
    logic [STAGES-1:0] invb_q, invb_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  f_q   [STAGES];
    logic [WIDTH-1:0]  f_d   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    logic [SEG-1:0]    sum_s [STAGES];
    logic [STAGES-1:0] cout_s;
    logic              cmsb_s [STAGES];

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_f_q,     out_f_d;
    flags_t            flags_q,     flags_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

    logic              adv_s;
    logic              accept_s;
    logic [WIDTH-1:0]  fin_s;

    // The whole pipeline advances together; a held result freezes it.
    assign adv_s    = ~out_valid_q | out_ready;
    assign in_ready = adv_s | ~rst_n;
    assign accept_s = in_valid & in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        seg_cla_adder #(.SEG(SEG)) u_cla (
            .a     (a_q[k][k*SEG +: SEG]),
            .b     (b_q[k][k*SEG +: SEG]),
            .cin   (c_q[k]),
            .f     (sum_s[k]),
            .cout  (cout_s[k]),
            .c_msb (cmsb_s[k])
        );
    end

    // Next-state for every bank and the output register.
    always_comb begin
        vld_d  = vld_q;
        c_d    = c_q;
        zacc_d = zacc_q;
        invb_d = invb_q;
        a_d    = a_q;
        b_d    = b_q;
        f_d    = f_q;
        tag_d  = tag_q;

        // Mode decode happens once, at accept.
        vld_d[0]  = accept_s;
        a_d[0]    = in_a;
        b_d[0]    = in_b ^ {WIDTH{in_op[0]}};
        c_d[0]    = calc_c0(in_op, in_cin);
        zacc_d[0] = 1'b1;
        invb_d[0] = in_op[0];
        f_d[0]    = {WIDTH{1'b0}};
        tag_d[0]  = in_tag;

        // Bubbles shift along with real ops.
        for (int k = 0; k < LAST; k++) begin
            vld_d[k+1]              = vld_q[k];
            a_d[k+1]                = a_q[k];
            b_d[k+1]                = b_q[k];
            c_d[k+1]                = cout_s[k];
            zacc_d[k+1]             = zacc_q[k] & (sum_s[k] == {SEG{1'b0}});
            invb_d[k+1]             = invb_q[k];
            tag_d[k+1]              = tag_q[k];
            f_d[k+1]                = f_q[k];
            f_d[k+1][k*SEG +: SEG]  = sum_s[k];
        end

        fin_s                     = f_q[LAST];
        fin_s[LAST*SEG +: SEG]    = sum_s[LAST];

        out_valid_d = vld_q[LAST];
        if (vld_q[LAST]) begin
            out_f_d    = fin_s;
            flags_d.cf = cout_s[LAST] ^ invb_q[LAST];
            flags_d.zf = zacc_q[LAST] & (sum_s[LAST] == {SEG{1'b0}});
            flags_d.of = cout_s[LAST] ^ cmsb_s[LAST];
            flags_d.sf = fin_s[WIDTH-1];
            out_tag_d  = tag_q[LAST];
        end else begin
            out_f_d    = out_f_q;
            flags_d    = flags_q;
            out_tag_d  = out_tag_q;
        end
    end

    // Stage and output registers: cleared on reset, frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= {STAGES{1'b0}};
            c_q         <= {STAGES{1'b0}};
            zacc_q      <= {STAGES{1'b0}};
            invb_q      <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= {WIDTH{1'b0}};
                b_q[k]   <= {WIDTH{1'b0}};
                f_q[k]   <= {WIDTH{1'b0}};
                tag_q[k] <= {TAG_W{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_f_q     <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
            out_tag_q   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            vld_q       <= vld_d;
            c_q         <= c_d;
            zacc_q      <= zacc_d;
            invb_q      <= invb_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            flags_q     <= flags_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_cf    = flags_q.cf;
    assign out_zf    = flags_q.zf;
    assign out_of    = flags_q.of;
    assign out_sf    = flags_q.sf;
    assign out_tag   = out_tag_q;

endmodule
